// File: rtl/fft_bf_sequencer.sv
// Butterfly sequencer for the in-place radix-2 DIT FFT engine.
// Walks stages and butterflies. Issues one U/V/twiddle address triple per
// handshake and counts butterflies that have been issued but not yet written
// back. At every stage boundary it drains, so that stage s+1 never reads a
// location that stage s has not yet written.
module fft_bf_sequencer #(
    parameter int FFT_SIZE        = 1024,
    parameter int MAX_OUTSTANDING = 4,
    localparam int L  = $clog2(FFT_SIZE),
    localparam int AW = L,
    localparam int SW = $clog2(L)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          bf_valid_o,
    input  logic          bf_ready_i,
    output logic [AW-1:0] u_addr_o,
    output logic [AW-1:0] v_addr_o,
    output logic [AW-1:0] tw_addr_o,
    output logic [SW-1:0] stage_o,
    output logic          last_bf_o,
    input  logic          wb_done_i,
    output logic          err_o
);

    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_ISSUE = 2'd1;
    localparam logic [1:0]    ST_DRAIN = 2'd2;
    localparam logic [1:0]    ST_DONE  = 2'd3;
    localparam logic [AW-1:0] J_LAST   = AW'(FFT_SIZE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(L - 1);
    localparam logic [3:0]    MAX_OUT  = 4'(MAX_OUTSTANDING);

    logic [1:0]    state_r, state_n;
    logic [SW-1:0] s_r, s_n;
    logic [AW-1:0] j_r, j_n;
    logic [3:0]    out_r, out_n;
    logic          err_r, err_n;

    logic          valid_s;
    logic          hs_s;
    logic          last_j_s;
    logic          last_s_s;
    logic          drain_exit_s;

    logic [AW-1:0] d_s;
    logic [AW-1:0] k_s;
    logic [AW-1:0] g_s;
    logic [AW-1:0] u_s;
    logic [AW-1:0] v_s;
    logic [AW-1:0] tw_s;
    logic [SW-1:0] tw_sh_s;

    // Handshake and boundary decode from the registered sequencing state.
    always_comb begin
        valid_s      = (state_r == ST_ISSUE) && (out_r < MAX_OUT);
        hs_s         = valid_s && bf_ready_i;
        last_j_s     = (j_r == J_LAST);
        last_s_s     = (s_r == S_LAST);
        // The last write-back may land in the drain cycle itself.
        drain_exit_s = (out_r == 4'd0) || ((out_r == 4'd1) && wb_done_i);
    end

    // Address generation: split j into group g and offset k within the group.
    always_comb begin
        d_s     = AW'(1) << s_r;
        k_s     = j_r & (d_s - AW'(1));
        g_s     = j_r >> s_r;
        u_s     = ((g_s << s_r) << 1'b1) + k_s;
        v_s     = u_s + d_s;
        tw_sh_s = S_LAST - s_r;
        tw_s    = k_s << tw_sh_s;
    end

    // Next-state logic for the FSM, the butterfly counters and the in-flight tracker.
    always_comb begin
        state_n = state_r;
        s_n     = s_r;
        j_n     = j_r;
        out_n   = out_r;
        err_n   = err_r;

        // An issue and a write-back in the same cycle cancel out.
        if (hs_s && !wb_done_i) begin
            out_n = out_r + 4'd1;
        end else if (!hs_s && wb_done_i) begin
            if (out_r == 4'd0) begin
                err_n = 1'b1;
            end else begin
                out_n = out_r - 4'd1;
            end
        end else begin
            out_n = out_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_n = ST_ISSUE;
                    s_n     = {SW{1'b0}};
                    j_n     = {AW{1'b0}};
                    out_n   = 4'd0;
                    err_n   = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (hs_s) begin
                    if (last_j_s) begin
                        state_n = ST_DRAIN;
                    end else begin
                        j_n = j_r + AW'(1);
                    end
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (drain_exit_s) begin
                    if (last_s_s) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ISSUE;
                        s_n     = s_r + SW'(1);
                        j_n     = {AW{1'b0}};
                    end
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset discards any in-flight count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            s_r     <= {SW{1'b0}};
            j_r     <= {AW{1'b0}};
            out_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            s_r     <= s_n;
            j_r     <= j_n;
            out_r   <= out_n;
            err_r   <= err_n;
        end
    end

    // Outputs depend only on registered state, so there is no input-to-output path.
    assign busy_o     = (state_r != ST_IDLE);
    assign done_o     = (state_r == ST_DONE);
    assign bf_valid_o = valid_s;
    assign last_bf_o  = valid_s && last_s_s && last_j_s;
    assign u_addr_o   = u_s;
    assign v_addr_o   = v_s;
    assign tw_addr_o  = tw_s;
    assign stage_o    = s_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Self-checking bench for fft_bf_sequencer (FFT_SIZE=8, MAX_OUTSTANDING=2).
// A behavioural model derived from the stage/group/butterfly loops is
// compared against the DUT on every cycle. Directed scenarios pin the model
// to hand-computed sequences and timing.
module tb_fft_bf_sequencer;

    localparam int N     = 8;
    localparam int MAXO  = 2;
    localparam int L     = 3;
    localparam int HALF  = N / 2;
    localparam int TOTAL = L * HALF;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start_i    = 1'b0;
    logic       bf_ready_i = 1'b0;
    logic       wb_done_i  = 1'b0;
    logic       busy_o, done_o, bf_valid_o, last_bf_o, err_o;
    logic [2:0] u_addr_o, v_addr_o, tw_addr_o;
    logic [1:0] stage_o;

    fft_bf_sequencer #(.FFT_SIZE(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .bf_valid_o (bf_valid_o),
        .bf_ready_i (bf_ready_i),
        .u_addr_o   (u_addr_o),
        .v_addr_o   (v_addr_o),
        .tw_addr_o  (tw_addr_o),
        .stage_o    (stage_o),
        .last_bf_o  (last_bf_o),
        .wb_done_i  (wb_done_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected butterfly list, built from the nested stage/group/butterfly loops.
    int exp_u[TOTAL];
    int exp_v[TOTAL];
    int exp_tw[TOTAL];

    initial begin
        for (int s = 0; s < L; s++) begin
            for (int g = 0; g < HALF / (1 << s); g++) begin
                for (int k = 0; k < (1 << s); k++) begin
                    exp_u[s*HALF + g*(1 << s) + k]  = g * 2 * (1 << s) + k;
                    exp_v[s*HALF + g*(1 << s) + k]  = g * 2 * (1 << s) + k + (1 << s);
                    exp_tw[s*HALF + g*(1 << s) + k] = k * (N / (2 * (1 << s)));
                end
            end
        end
    end

    // Behavioural model: global butterfly index, in-flight count and phase flags.
    logic m_busy = 1'b0, m_drain = 1'b0, m_done = 1'b0, m_err = 1'b0, m_hs_prev = 1'b0;
    int   m_bf = 0, m_stage = 0, m_out = 0;
    logic m_valid;
    assign m_valid = m_busy && !m_drain && !m_done && (m_out < MAXO);

    initial begin
        logic hs_m;
        int   prev_out;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_err = 1'b0;
                m_hs_prev = 1'b0; m_bf = 0; m_stage = 0; m_out = 0;
            end else begin
                hs_m     = m_valid && bf_ready_i;
                prev_out = m_out;
                if (hs_m && !wb_done_i) m_out = m_out + 1;
                else if (!hs_m && wb_done_i) begin
                    if (m_out == 0) m_err = 1'b1;
                    else m_out = m_out - 1;
                end
                m_hs_prev = hs_m;
                if (!m_busy) begin
                    if (start_i) begin
                        m_busy = 1'b1; m_drain = 1'b0; m_done = 1'b0;
                        m_bf = 0; m_stage = 0; m_out = 0; m_err = 1'b0;
                    end
                end else if (m_done) begin
                    m_done = 1'b0;
                    m_busy = 1'b0;
                end else if (m_drain) begin
                    if (prev_out == 0 || (prev_out == 1 && wb_done_i)) begin
                        if (m_stage == L - 1) m_done = 1'b1;
                        else begin
                            m_stage = m_stage + 1;
                            m_drain = 1'b0;
                        end
                    end
                end else if (hs_m) begin
                    m_bf = m_bf + 1;
                    if (m_bf % HALF == 0) m_drain = 1'b1;
                end
            end
        end
    end

    // Stimulus controls and per-transform log.
    int   wb_mode    = 2;      // 0: write-back one cycle after handshake, 1: random, 2: none, 3: wb_force
    logic wb_force   = 1'b0;
    logic ready_fix  = 1'b1;
    logic rand_ready = 1'b0;
    logic start_req  = 1'b0;
    int   cyc        = 0;
    int   hs_count   = 0;
    int   done_cyc   = -1;
    int   log_u[64], log_v[64], log_tw[64], log_cyc[64], log_st[64];
    logic log_last[64];

    int   ref_u[TOTAL]   = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int   ref_v[TOTAL]   = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int   ref_tw[TOTAL]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int   ref_cyc[TOTAL] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 13, 14};

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    // One cycle: compare DUT against the model, then drive inputs and log handshakes.
    task automatic step();
        @(negedge clk);
        chk1("busy", busy_o, m_busy);
        chk1("done", done_o, m_done);
        chk1("valid", bf_valid_o, m_valid);
        chk1("last", last_bf_o, m_valid && (m_bf == TOTAL - 1));
        chk1("err", err_o, m_err);
        chkn("stage", int'(stage_o), m_stage);
        if (m_valid) begin
            chkn("u_addr", int'(u_addr_o), exp_u[m_bf]);
            chkn("v_addr", int'(v_addr_o), exp_v[m_bf]);
            chkn("tw_addr", int'(tw_addr_o), exp_tw[m_bf]);
        end
        cyc++;
        start_i   = start_req;
        start_req = 1'b0;
        case (wb_mode)
            0:       wb_done_i = m_hs_prev;
            1:       wb_done_i = (m_out > 0) && ($urandom_range(1, 0) == 1);
            2:       wb_done_i = 1'b0;
            default: wb_done_i = wb_force;
        endcase
        bf_ready_i = rand_ready ? ($urandom_range(3, 0) != 0) : ready_fix;
        if (bf_valid_o && bf_ready_i) begin
            if (hs_count < 64) begin
                log_u[hs_count]    = int'(u_addr_o);
                log_v[hs_count]    = int'(v_addr_o);
                log_tw[hs_count]   = int'(tw_addr_o);
                log_st[hs_count]   = int'(stage_o);
                log_last[hs_count] = last_bf_o;
                log_cyc[hs_count]  = cyc;
            end
            hs_count++;
        end
        if (done_o && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic begin_xfer();
        hs_count  = 0;
        done_cyc  = -1;
        cyc       = -1;
        start_req = 1'b1;
        step();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cyc < 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cyc < 0) timeout_fail(name);
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            step();
            n++;
        end
        if (hs_count < target) timeout_fail(name);
    endtask

    // Reference timing run; optionally pokes start_i while busy.
    task automatic run_reference(input logic poke);
        int n = 0;
        begin_xfer();
        while (done_cyc < 0 && n < 40) begin
            if (poke && (cyc == 6 || cyc == 11)) start_req = 1'b1;
            step();
            n++;
        end
        if (done_cyc < 0) timeout_fail("ref_done");
        chkn("ref_done_cycle", done_cyc, 16);
        chkn("ref_hs_count", hs_count, TOTAL);
        for (int i = 0; i < TOTAL; i++) begin
            chkn("ref_u", log_u[i], ref_u[i]);
            chkn("ref_v", log_v[i], ref_v[i]);
            chkn("ref_tw", log_tw[i], ref_tw[i]);
            chkn("ref_cycle", log_cyc[i], ref_cyc[i]);
            chkn("ref_stage", log_st[i], i / HALF);
            chk1("ref_last", log_last[i], (i == TOTAL - 1));
        end
        step();
        chk1("ref_idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_valid", bf_valid_o, 1'b0);
        chk1("rst_last", last_bf_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chkn("rst_u", int'(u_addr_o), 0);
        chkn("rst_v", int'(v_addr_o), 1);
        chkn("rst_tw", int'(tw_addr_o), 0);
        chkn("rst_stage", int'(stage_o), 0);
        rst_n = 1'b1;
        step();
        step();

        // Address sequence and reference timing, then again with ignored starts.
        wb_mode = 0;
        run_reference(1'b0);
        run_reference(1'b1);

        // Outstanding cap.
        wb_mode = 2;
        begin_xfer();
        repeat (10) step();
        chkn("cap_hs_count", hs_count, 2);
        chk1("cap_valid_low", bf_valid_o, 1'b0);
        wb_mode  = 3;
        wb_force = 1'b1;
        step();
        wb_force = 1'b0;
        repeat (10) step();
        chkn("cap_one_more", hs_count, 3);
        chk1("cap_valid_low2", bf_valid_o, 1'b0);
        wb_mode = 1;
        wait_done("cap_done", 300);
        step();

        // Backpressure at stage 1, j=2.
        wb_mode = 0;
        begin_xfer();
        wait_hs("bp_reach", 6, 30);
        ready_fix = 1'b0;
        repeat (5) begin
            step();
            chk1("bp_valid_held", bf_valid_o, 1'b1);
            chkn("bp_u_held", int'(u_addr_o), 4);
            chkn("bp_v_held", int'(v_addr_o), 6);
            chkn("bp_tw_held", int'(tw_addr_o), 0);
        end
        ready_fix = 1'b1;
        wait_done("bp_done", 60);
        begin
            int cnt = 0;
            for (int i = 0; i < TOTAL; i++)
                if (log_u[i] == 4 && log_v[i] == 6) cnt++;
            chkn("bp_issued_once", cnt, 1);
        end
        chkn("bp_hs_count", hs_count, TOTAL);
        step();

        // Stage barrier: hold back the last stage-0 write-back for 10 cycles.
        wb_mode = 0;
        begin_xfer();
        wait_hs("bar_reach", 4, 30);
        wb_mode  = 3;
        wb_force = 1'b0;
        repeat (10) begin
            step();
            chk1("bar_valid_low", bf_valid_o, 1'b0);
            chk1("bar_busy", busy_o, 1'b1);
        end
        wb_force = 1'b1;
        step();
        chk1("bar_valid_wb_cycle", bf_valid_o, 1'b0);
        wb_force = 1'b0;
        step();
        chk1("bar_valid_after", bf_valid_o, 1'b1);
        chkn("bar_stage_after", int'(stage_o), 1);
        chkn("bar_u_after", int'(u_addr_o), 0);
        chkn("bar_v_after", int'(v_addr_o), 2);
        wb_mode = 0;
        wait_done("bar_done", 60);
        step();

        // Protocol error while idle, cleared by the next start.
        wb_mode  = 3;
        wb_force = 1'b1;
        step();
        wb_force = 1'b0;
        step();
        chk1("err_set", err_o, 1'b1);
        repeat (3) step();
        chk1("err_sticky", err_o, 1'b1);
        wb_mode = 0;
        begin_xfer();
        step();
        chk1("err_cleared", err_o, 1'b0);
        wait_done("err_done", 60);
        step();

        // Asynchronous reset in the middle of stage 1, then a fresh transform.
        begin_xfer();
        wait_hs("rst_reach", 5, 30);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_busy", busy_o, 1'b0);
        chk1("arst_valid", bf_valid_o, 1'b0);
        chk1("arst_done", done_o, 1'b0);
        chk1("arst_last", last_bf_o, 1'b0);
        chk1("arst_err", err_o, 1'b0);
        chkn("arst_u", int'(u_addr_o), 0);
        chkn("arst_v", int'(v_addr_o), 1);
        chkn("arst_tw", int'(tw_addr_o), 0);
        chkn("arst_stage", int'(stage_o), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        begin_xfer();
        wait_done("arst_rerun", 60);
        chkn("arst_rerun_done", done_cyc, 16);
        chkn("arst_rerun_hs", hs_count, TOTAL);
        chkn("arst_rerun_first_u", log_u[0], 0);
        chkn("arst_rerun_first_v", log_v[0], 1);
        chkn("arst_rerun_first_cyc", log_cyc[0], 1);
        chkn("arst_rerun_last_u", log_u[TOTAL-1], 3);
        chkn("arst_rerun_last_v", log_v[TOTAL-1], 7);
        step();

        // Randomised ready, write-back timing and stray starts.
        rand_ready = 1'b1;
        wb_mode    = 1;
        for (int t = 0; t < 6; t++) begin
            int n = 0;
            begin_xfer();
            while (done_cyc < 0 && n < 400) begin
                if ($urandom_range(15, 0) == 0) start_req = 1'b1;
                step();
                n++;
            end
            if (done_cyc < 0) timeout_fail("rand_done");
            chkn("rand_hs_count", hs_count, TOTAL);
            step();
            repeat ($urandom_range(3, 0)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_bf_sequencer.md
# fft_bf_sequencer

Butterfly sequencer for the in-place radix-2 DIT FFT engine. It walks all stages, groups and butterflies, and issues one butterfly at a time to the butterfly datapath as U/V data-RAM addresses plus a twiddle ROM address. It tracks butterflies that are issued but not yet written back. At each stage boundary it stalls so stage s+1 never reads a location that stage s has not yet written. It sits between the ingest FSM, which asserts start after the bit-reversed load, and the butterfly/RAM pipeline.

## Interface
- FFT_SIZE, 1024, transform length; power of 2, ≥4; L = log2(FFT_SIZE), AW = L
- MAX_OUTSTANDING, 4, max butterflies in flight (issued, not written back); 1..15
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  start a transform; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  single-cycle pulse when the transform is complete
- bf_valid_o  out  1  butterfly request valid
- bf_ready_i  in  1  datapath accepts request
- u_addr_o  out  AW  upper-leg RAM address
- v_addr_o  out  AW  lower-leg RAM address (u + d)
- tw_addr_o  out  AW  twiddle ROM index
- stage_o  out  $clog2(L)  current stage index
- last_bf_o  out  1  request is the last butterfly of the whole transform
- wb_done_i  in  1  one butterfly write-back completed this cycle
- err_o  out  1  sticky protocol error; cleared on accepted start_i

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:** start_i goes to ISSUE. The transition clears the counters (s=0, j=0, outstanding=0) and clears err_o.
- **ISSUE:** bf_valid_o = (outstanding < MAX_OUTSTANDING).
  - A handshake is bf_valid_o && bf_ready_i. On handshake, j increments.
  - On the handshake with j = FFT_SIZE/2-1, go to DRAIN.
- **DRAIN:** bf_valid_o = 0.
  - Exit when outstanding==0, or when outstanding==1 && wb_done_i.
  - On exit: if s==L-1, go to DONE; else s++, j=0, go to ISSUE.
- **DONE:** done_o = 1 for one cycle, then go to IDLE.
- Address math, with per-stage linear index j in 0..FFT_SIZE/2-1:
  - d = 1<<s, k = j & (d-1), g = j >> s
  - u = (g << (s+1)) + k
  - v = u + d
  - tw = k << (L-1-s)
  - All values are unsigned AW-bit and never overflow.
- Address outputs are combinational from the registered s and j. They are held stable while bf_valid_o && !bf_ready_i.
- Outstanding counter:
  - Issue only: +1.
  - wb_done_i only: -1.
  - Both in the same cycle: unchanged.
- wb_done_i while outstanding==0 (with no same-cycle issue): the counter stays 0 and err_o is set.
- Once asserted, bf_valid_o cannot drop before the handshake, because outstanding only decreases while waiting.
- last_bf_o = bf_valid_o && s==L-1 && j==FFT_SIZE/2-1.
- start_i outside IDLE is ignored.
- Reset values:
  - State IDLE; s, j and outstanding = 0.
  - busy_o, done_o, bf_valid_o, last_bf_o and err_o = 0.
  - u_addr_o = 0, v_addr_o = 1, tw_addr_o = 0, stage_o = 0.
- Reset asserted mid-transform returns to IDLE immediately with all outputs at reset values. The in-flight count is discarded.

## Timing
- start_i sampled high in cycle 0 → busy_o and bf_valid_o high in cycle 1 (u=0, v=1, tw=0).
- With bf_ready_i=1 and no stall, one butterfly issues per cycle.
- Stage-to-stage bubble is 1 cycle: the DRAIN cycle, provided the last write-back arrives in or before that cycle.
- Reference timing: FFT_SIZE=8, MAX_OUTSTANDING=4, bf_ready_i=1, wb_done_i = handshake delayed 1 cycle.
  - Stage 0 issues in cycles 1–4, DRAIN in cycle 5.
  - Stage 1 issues in 6–9, DRAIN in 10.
  - Stage 2 issues in 11–14, DRAIN in 15.
  - done_o in cycle 16; busy_o low and IDLE in cycle 17.
- done_o and busy_o are never both low while a stage is pending.

## Test plan
- **Address sequence:** FFT_SIZE=8, start, ready=1, write-back delay 1.
  - Stage 0 (u,v,tw): (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - done_o in cycle 16; last_bf_o only on (3,7,3).
- **Outstanding cap:** MAX_OUTSTANDING=2, wb_done_i never asserted → exactly 2 handshakes, then bf_valid_o stays low. One wb_done_i pulse → exactly one more issue.
- **Backpressure:** bf_ready_i low for 5 cycles at j=2 of stage 1 → bf_valid_o stays high and u/v/tw stay at (4,6,0) throughout; that butterfly issues once when ready returns.
- **Stage barrier:** hold the write-back of the last stage-0 butterfly for 10 cycles → no stage-1 bf_valid_o until the cycle after that wb_done_i.
- **Protocol error:** wb_done_i while idle, with outstanding==0 → err_o=1 and stays high. Next start_i → err_o=0.
- **Reset and ignored start:** start_i pulses while busy → no effect on the sequence or completion cycle. rst_ni low mid-stage 1 → all outputs return to reset values asynchronously. A new start then runs a full transform from stage 0.
